// File: rtl/pc_sequencer_if.sv
// Control/status bundle for pc_sequencer: run request, branch controls, PC and run status.
interface pc_sequencer_if #(
  parameter int PCW  = 8,
  parameter int CNTW = 16
);
  logic            start;
  logic [PCW-1:0]  start_pc;
  logic [PCW-1:0]  end_pc;
  logic            stall;
  logic            branch_en;
  logic            branch_rel;
  logic [PCW-1:0]  branch_target;
  logic [PCW-1:0]  pc;
  logic            pc_valid;
  logic            busy;
  logic            halted;
  logic            done;
  logic [CNTW-1:0] cycle_count;

  modport master (
    output start, start_pc, end_pc, stall, branch_en, branch_rel, branch_target,
    input  pc, pc_valid, busy, halted, done, cycle_count
  );

  modport slave (
    input  start, start_pc, end_pc, stall, branch_en, branch_rel, branch_target,
    output pc, pc_valid, busy, halted, done, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: runs from start_pc to end_pc with stall, relative/absolute
// branches and a saturating run-cycle counter; IDLE -> RUN -> HALT.
module pc_sequencer #(
  parameter int PCW  = 8,
  parameter int CNTW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state_q;
  logic [PCW-1:0]  pc_q;
  logic [PCW-1:0]  end_q;
  logic [CNTW-1:0] cnt_q;
  logic            done_q;

  logic [PCW-1:0]  pc_d;
  logic [CNTW-1:0] cnt_d;

  // Non-stall, non-end PC successor; relative offsets wrap modulo 2^PCW.
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (bus.branch_en) begin
      pc_d = bus.branch_rel ? (pc_q + bus.branch_target) : bus.branch_target;
    end
    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, HALT: begin
          if (bus.start) begin
            state_q <= RUN;
            pc_q    <= bus.start_pc;
            end_q   <= bus.end_pc;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (!bus.stall) begin
            if (pc_q == end_q) begin
              state_q <= HALT;
              done_q  <= 1'b1;
            end else begin
              pc_q <= pc_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.halted      = (state_q == HALT);
  assign bus.pc_valid    = (state_q == RUN) && !bus.stall;
  assign bus.done        = done_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model;
// a second instance with a 3-bit counter shares the inputs to exercise saturation.
module tb_pc_sequencer;
  localparam int PCW   = 8;
  localparam int CNTW  = 16;
  localparam int CNTW2 = 3;
  localparam int PMOD  = 2 ** PCW;
  localparam int CMAX  = 2 ** CNTW - 1;
  localparam int CMAX2 = 2 ** CNTW2 - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pc_sequencer_if #(.PCW(PCW), .CNTW(CNTW))  bus  ();
  pc_sequencer_if #(.PCW(PCW), .CNTW(CNTW2)) bus2 ();

  pc_sequencer #(.PCW(PCW), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  pc_sequencer #(.PCW(PCW), .CNTW(CNTW2)) dut_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2.slave)
  );

  assign bus2.start         = bus.start;
  assign bus2.start_pc      = bus.start_pc;
  assign bus2.end_pc        = bus.end_pc;
  assign bus2.stall         = bus.stall;
  assign bus2.branch_en     = bus.branch_en;
  assign bus2.branch_rel    = bus.branch_rel;
  assign bus2.branch_target = bus.branch_target;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
  mstate_t m_st;
  int      m_pc, m_end, m_cnt;
  bit      m_done;

  task automatic model_reset();
    m_st = M_IDLE; m_pc = 0; m_end = 0; m_cnt = 0; m_done = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_st != M_RUN) begin
      m_done = 0;
      if (bus.start) begin
        m_st = M_RUN; m_pc = int'(bus.start_pc); m_end = int'(bus.end_pc); m_cnt = 0;
      end
    end else begin
      m_done = 0;
      m_cnt  = m_cnt + 1;
      if (!bus.stall) begin
        if (m_pc == m_end) begin
          m_st = M_HALT; m_done = 1;
        end else if (bus.branch_en) begin
          m_pc = bus.branch_rel ? (m_pc + int'(bus.branch_target)) % PMOD : int'(bus.branch_target);
        end else begin
          m_pc = (m_pc + 1) % PMOD;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_pc"},       bus.pc,       m_pc);
    chk({tag, "_busy"},     bus.busy,     (m_st == M_RUN));
    chk({tag, "_halted"},   bus.halted,   (m_st == M_HALT));
    chk({tag, "_done"},     bus.done,     m_done);
    chk({tag, "_pcvalid"},  bus.pc_valid, (m_st == M_RUN) && !bus.stall);
    chk({tag, "_cnt"},      bus.cycle_count,  (m_cnt > CMAX)  ? CMAX  : m_cnt);
    chk({tag, "_cnt_sat"},  bus2.cycle_count, (m_cnt > CMAX2) ? CMAX2 : m_cnt);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare(tag);
  endtask

  task automatic drive(input bit st, input int spc, input int epc, input bit stl,
                       input bit ben, input bit brel, input int tgt);
    bus.start         = st;
    bus.start_pc      = PCW'(spc);
    bus.end_pc        = PCW'(epc);
    bus.stall         = stl;
    bus.branch_en     = ben;
    bus.branch_rel    = brel;
    bus.branch_target = PCW'(tgt);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    compare("reset");
    chk("reset_pc_const", bus.pc, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Linear run 0x10..0x13
    drive(1, 'h10, 'h13, 0, 0, 0, 0);
    step("lin0");  chk("lin0_pc_const", bus.pc, 'h10);
    bus.start = 0;
    step("lin1");  chk("lin1_pc_const", bus.pc, 'h11);
    step("lin2");  chk("lin2_pc_const", bus.pc, 'h12);
    step("lin3");  chk("lin3_pc_const", bus.pc, 'h13);
    step("lin_h"); chk("lin_done_const", bus.done, 1); chk("lin_cnt_const", bus.cycle_count, 4);
    step("lin_h2"); chk("lin_done_drop", bus.done, 0); chk("lin_hold_pc", bus.pc, 'h13);

    // start_pc == end_pc gives exactly one RUN cycle
    drive(1, 'h77, 'h77, 0, 0, 0, 0);
    step("one0");
    bus.start = 0;
    step("one_h"); chk("one_cnt_const", bus.cycle_count, 1); chk("one_halt_const", bus.halted, 1);

    // Relative then absolute branch
    drive(1, 'h05, 'h40, 0, 0, 0, 0);
    step("br0");
    drive(0, 0, 0, 0, 1, 1, 'hFE);
    step("br_rel"); chk("br_rel_const", bus.pc, 'h03);
    drive(0, 0, 0, 0, 1, 0, 'h40);
    step("br_abs"); chk("br_abs_const", bus.pc, 'h40);
    bus.branch_en = 0;
    step("br_h"); chk("br_halt_const", bus.halted, 1);

    // Wrap and stall
    drive(1, 'hFE, 'h01, 0, 0, 0, 0);
    step("wr0");
    bus.start = 0;
    step("wr1");
    bus.stall = 1; #1;
    chk("wr_stall_pcvalid", bus.pc_valid, 0);
    step("wr_s1"); chk("wr_s1_pc_const", bus.pc, 'hFF);
    step("wr_s2");
    bus.stall = 0;
    step("wr2"); chk("wr2_pc_const", bus.pc, 'h00);
    step("wr3"); chk("wr3_pc_const", bus.pc, 'h01);
    step("wr_h"); chk("wr_cnt_const", bus.cycle_count, 6);

    // Stall held at end PC, branch at end ignored
    drive(1, 'h20, 'h21, 0, 0, 0, 0);
    step("se0");
    bus.start = 0;
    step("se1");
    drive(0, 0, 0, 1, 1, 0, 'h99);
    for (int unsigned i = 0; i < 3; i++) begin
      step("se_stall"); chk("se_no_done", bus.done, 0);
    end
    bus.stall = 0;
    step("se_h"); chk("se_done_const", bus.done, 1); chk("se_pc_const", bus.pc, 'h21);
    bus.branch_en = 0;

    // Asynchronous reset mid-run, ignored start while running, restart in done cycle
    drive(1, 'h10, 'h13, 0, 0, 0, 0);
    step("rr0");
    bus.start = 0;
    step("rr1");
    step("rr2");
    #3 rst_n = 1'b0;
    #1 model_reset();
    compare("rr_async");
    chk("rr_async_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rr_idle1");
    step("rr_idle2"); chk("rr_no_done", bus.done, 0);
    drive(1, 'h30, 'h32, 0, 0, 0, 0);
    step("ig0");
    drive(1, 'h50, 'h51, 0, 0, 0, 0);
    step("ig1"); chk("ig_start_ignored", bus.pc, 'h31);
    step("ig2");
    bus.start = 0;
    step("ig_h"); chk("ig_done_const", bus.done, 1);
    drive(1, 'h60, 'h61, 0, 0, 0, 0);
    step("rs0"); chk("rs_pc_const", bus.pc, 'h60); chk("rs_done_drop", bus.done, 0);
    bus.start = 0;
    step("rs1");
    step("rs_h");

    // Randomized traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      int spc;
      spc = int'($urandom_range(0, PMOD - 1));
      drive(($urandom_range(0, 7) == 0), spc, (spc + int'($urandom_range(0, 12))) % PMOD,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
            int'($urandom_range(0, PMOD - 1)));
      if (bus.branch_rel && $urandom_range(0, 1) == 1)
        bus.branch_target = PCW'(int'($urandom_range(0, 16)) - 8);
      rst_n = ($urandom_range(0, 399) != 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The module SHALL have parameter PCW, default 8, meaning program-counter width in bits.
REQ-002 The module SHALL have parameter CNTW, default 16, meaning run-cycle counter width in bits.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset; ports follow in REQ-004..REQ-016.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin a program run.
REQ-007 start_pc  input  PCW  first PC of the run; sampled on accepted start.
REQ-008 end_pc  input  PCW  PC at which the run completes; sampled on accepted start.
REQ-009 stall  input  1  hold PC this cycle.
REQ-010 branch_en  input  1  take a branch this cycle.
REQ-011 branch_rel  input  1  1 = branch_target is a signed two's-complement offset; 0 = absolute PC.
REQ-012 branch_target  input  PCW  branch target or offset.
REQ-013 pc  output  PCW  current program counter.
REQ-014 pc_valid  output  1  pc is a fetch address this cycle.
REQ-015 busy / halted / done  output  1 each  run in progress / run completed (level) / one-cycle completion pulse.
REQ-016 cycle_count  output  CNTW  number of RUN-state cycles in the current or last run.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, HALT; busy = (state==RUN), halted = (state==HALT), pc_valid = (state==RUN && !stall).
REQ-018 In IDLE or HALT, start=1 at a clock edge SHALL: go to RUN; pc <= start_pc; end register <= end_pc; cycle_count <= 0; done <= 0.
REQ-019 start SHALL be ignored while in RUN; end_pc and start_pc SHALL be ignored except on an accepted start.
REQ-020 In RUN, cycle_count SHALL increment by 1 each cycle (stalled cycles included) and saturate at 2^CNTW-1.
REQ-021 In RUN, priority per cycle SHALL be: stall > end detection > branch > sequential increment.
REQ-022 stall=1 in RUN: pc, state, and end register SHALL hold; branch_en SHALL be ignored.
REQ-023 stall=0 and pc == end register: next state HALT, pc holds at end value, done = 1 for exactly the first HALT cycle; branch_en ignored.
REQ-024 Otherwise branch_en=1: pc <= branch_rel ? (pc + branch_target) mod 2^PCW : branch_target.
REQ-025 Otherwise: pc <= (pc + 1) mod 2^PCW; 2^PCW-1 wraps to 0.
REQ-026 start_pc == end_pc SHALL yield exactly one RUN cycle (cycle_count = 1) then HALT.
REQ-027 In HALT, pc, cycle_count and halted SHALL hold until an accepted start; done SHALL be 0 after its single pulse.
REQ-028 start in the same cycle that done is pulsing SHALL be accepted (HALT -> RUN) and done SHALL drop next cycle.
REQ-029 A run whose PC never equals end register SHALL remain in RUN indefinitely (no timeout).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, pc=0, end register=0, cycle_count=0, done=0, busy=0, halted=0, pc_valid=0, regardless of clock.
REQ-031 Reset asserted mid-run SHALL abort the run without a done pulse; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 Linear run: start, start_pc=0x10, end_pc=0x13, no stall -> pc 0x10,0x11,0x12,0x13 on successive RUN cycles, then HALT, done one-cycle pulse, cycle_count=4, pc holds 0x13.
REQ-033 Relative/absolute branch: start_pc=0x05, end_pc=0x40; at pc=0x05 branch_rel=1, target=0xFE -> next pc 0x03; at pc=0x03 branch_rel=0, target=0x40 -> next pc 0x40, then HALT.
REQ-034 Wrap and stall: start_pc=0xFE, end_pc=0x01, stall=1 for 2 cycles at pc=0xFF -> pc 0xFE,0xFF,0xFF,0xFF,0x00,0x01, pc_valid low on stalled cycles, cycle_count=6.
REQ-035 Stall at end: pc=end with stall=1 for 3 cycles -> stays RUN, no done until stall drops; branch_en=1 at pc=end ignored.
REQ-036 Reset/restart: rst_n low at pc=0x12 of REQ-032 run -> all outputs 0 asynchronously, no done; start during RUN ignored; start in done cycle -> RUN next cycle with new start_pc.
